// File: rtl/sdpb_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdpb_fifo_pkg
// Brief    : Shared sizing constants for the SDPB-backed FWFT FIFO controller.
// Revision : 1.0 - initial release
// ============================================================================
package sdpb_fifo_pkg;

    localparam int AW        = 11;
    localparam int DW        = 16;
    localparam int DEPTH     = 2 ** AW;
    localparam int BUF_DEPTH = 2;
    localparam int AF_LVL    = 1792;

endpackage : sdpb_fifo_pkg
`default_nettype wire

// File: rtl/sdpb_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sdpb_fifo_ctrl_if
// Brief    : Write/read handshake and status bundle of the FIFO controller.
// Revision : 1.0 - initial release
// ============================================================================
interface sdpb_fifo_ctrl_if #(
    parameter int AW = sdpb_fifo_pkg::AW,
    parameter int DW = sdpb_fifo_pkg::DW
);
    logic          clr;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          almost_full;
    logic          ovf;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic [AW:0]   ram_cnt;

    modport master (
        output clr, wr_en, wr_data, rd_ready,
        input  full, almost_full, ovf, rd_valid, rd_data, ram_cnt
    );

    modport slave (
        input  clr, wr_en, wr_data, rd_ready,
        output full, almost_full, ovf, rd_valid, rd_data, ram_cnt
    );

endinterface : sdpb_fifo_ctrl_if
`default_nettype wire

// File: rtl/sdpb_fifo_ctrl_fwft_out_buf.sv
`default_nettype none
// ============================================================================
// Module   : fwft_out_buf
// Brief    : Two-entry push/pop skid buffer; entry 0 is always the head.
// Revision : 1.0 - initial release
// ============================================================================
module fwft_out_buf
    import sdpb_fifo_pkg::*;
#(
    parameter int DW = sdpb_fifo_pkg::DW
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          i_clr,
    input  wire logic          i_push,
    input  wire logic [DW-1:0] i_data,
    input  wire logic          i_pop,
    output logic               o_valid,
    output logic [DW-1:0]      o_data,
    output logic [1:0]         o_cnt
);

    logic [DW-1:0] r_e0;
    logic [DW-1:0] r_e1;
    logic [1:0]    r_cnt;
    logic          w_pop;

    assign w_pop   = i_pop && (r_cnt != 2'd0);
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_e0;
    assign o_cnt   = r_cnt;

    // Pushes beyond BUF_DEPTH cannot occur: the issuer reserves a slot first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e0  <= '0;
            r_e1  <= '0;
            r_cnt <= 2'd0;
        end else if (i_clr) begin
            r_e0  <= '0;
            r_e1  <= '0;
            r_cnt <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_e0 <= i_data;
                    else               r_e1 <= i_data;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_e0  <= r_e1;
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_e0 <= i_data;
                    end else begin
                        r_e0 <= r_e1;
                        r_e1 <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : fwft_out_buf
`default_nettype wire

// File: rtl/sdpb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sdpb_fifo_ctrl
// Brief    : FWFT FIFO sequencer for an external 2048x16 SDPB RAM (bypass read).
// Revision : 1.0 - initial release
// ============================================================================
module sdpb_fifo_ctrl
    import sdpb_fifo_pkg::*;
#(
    parameter int AW     = sdpb_fifo_pkg::AW,
    parameter int DW     = sdpb_fifo_pkg::DW,
    parameter int AF_LVL = sdpb_fifo_pkg::AF_LVL
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    sdpb_fifo_ctrl_if.slave    bus,
    output logic               ram_cea,
    output logic [AW-1:0]      ram_ada,
    output logic [DW-1:0]      ram_din,
    output logic               ram_ceb,
    output logic [AW-1:0]      ram_adb,
    output logic               ram_oce,
    output logic               ram_reset,
    input  wire logic [DW-1:0] ram_dout
);

    localparam logic [AW:0] c_af_lvl  = (AW+1)'(AF_LVL);
    localparam logic [2:0]  c_buf_dep = 3'(BUF_DEPTH);

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        r_inflight;
    logic        r_ovf;

    logic        w_full;
    logic        w_ram_empty;
    logic        w_accept;
    logic        w_issue;
    logic        w_pop;
    logic        w_push;
    logic        w_rd_valid;
    logic [1:0]  w_buf_cnt;
    logic [2:0]  w_occ;
    logic [AW:0] w_cnt;

    assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_ram_empty = (r_wptr == r_rptr);
    assign w_cnt       = r_wptr - r_rptr;

    // Enables are gated by rst_n so the RAM sees no traffic while in reset.
    assign w_accept = rst_n && !bus.clr && bus.wr_en && !w_full;
    assign w_pop    = w_rd_valid && bus.rd_ready;
    assign w_occ    = {1'b0, w_buf_cnt} + {2'b00, r_inflight};
    assign w_issue  = rst_n && !bus.clr && !w_ram_empty
                      && ((w_occ - {2'b00, w_pop}) < c_buf_dep);
    assign w_push   = r_inflight && !bus.clr;

    assign ram_cea   = w_accept;
    assign ram_ada   = r_wptr[AW-1:0];
    assign ram_din   = bus.wr_data;
    assign ram_ceb   = w_issue;
    assign ram_adb   = r_rptr[AW-1:0];
    assign ram_oce   = 1'b1;
    assign ram_reset = 1'b0;

    assign bus.full        = w_full;
    assign bus.almost_full = (w_cnt >= c_af_lvl);
    assign bus.ram_cnt     = w_cnt;
    assign bus.ovf         = r_ovf;
    assign bus.rd_valid    = w_rd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_inflight <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (bus.clr) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_inflight <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_accept)                 r_wptr <= r_wptr + 1'b1;
            if (w_issue)                  r_rptr <= r_rptr + 1'b1;
            if (bus.wr_en && w_full)      r_ovf  <= 1'b1;
            r_inflight <= w_issue;
        end
    end

    fwft_out_buf #(
        .DW (DW)
    ) u_out_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (bus.clr),
        .i_push  (w_push),
        .i_data  (ram_dout),
        .i_pop   (w_pop),
        .o_valid (w_rd_valid),
        .o_data  (bus.rd_data),
        .o_cnt   (w_buf_cnt)
    );

endmodule : sdpb_fifo_ctrl
`default_nettype wire

// File: tb/tb_sdpb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdpb_fifo_ctrl
// Brief    : Self-checking bench: vector table, directed corners, random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdpb_fifo_ctrl;

    localparam int DEPTH = 2048;
    localparam int AF    = 1792;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ram_cea, ram_ceb, ram_oce, ram_reset;
    logic [10:0] ram_ada, ram_adb;
    logic [15:0] ram_din, ram_dout;
    logic [15:0] mem [0:DEPTH-1];

    always #5 clk = ~clk;

    sdpb_fifo_ctrl_if bus ();

    sdpb_fifo_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ram_cea   (ram_cea),
        .ram_ada   (ram_ada),
        .ram_din   (ram_din),
        .ram_ceb   (ram_ceb),
        .ram_adb   (ram_adb),
        .ram_oce   (ram_oce),
        .ram_reset (ram_reset),
        .ram_dout  (ram_dout)
    );

    // RAM: registered read, no same-address collisions expected
    always @(posedge clk) begin
        if (ram_cea) mem[ram_ada] <= ram_din;
        if (ram_ceb) ram_dout <= mem[ram_adb];
    end

    int errors = 0;
    int checks = 0;
    int rd_count = 0;

    // Reference model: resident words, one in-flight slot, output words
    logic [15:0] ram_q[$];
    logic [15:0] buf_q[$];
    bit          fl_v;
    logic [15:0] fl_d;
    int          m_wptr, m_rptr;
    bit          m_ovf;

    typedef struct {
        bit          we;
        logic [15:0] wd;
        bit          rr;
        bit          cea;
        bit          ceb;
        bit          vld;
        logic [15:0] data;
        int          cnt;
    } vec_t;
    vec_t tv [5];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ram_q.delete();
        buf_q.delete();
        fl_v   = 1'b0;
        m_wptr = 0;
        m_rptr = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic drive(bit we, logic [15:0] wd, bit rr, bit cl);
        bit m_full, pop, accept, issue;
        bus.wr_en    = we;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        bus.clr      = cl;
        @(negedge clk);
        m_full = (ram_q.size() == DEPTH);
        pop    = (buf_q.size() > 0) && rr;
        accept = we && !m_full && !cl;
        issue  = !cl && (ram_q.size() > 0) && ((buf_q.size() + int'(fl_v) - int'(pop)) < 2);
        chk("rd_valid", 32'(bus.rd_valid), 32'(buf_q.size() > 0));
        if (buf_q.size() > 0) chk("rd_data", 32'(bus.rd_data), 32'(buf_q[0]));
        chk("ram_cnt", 32'(bus.ram_cnt), 32'(ram_q.size()));
        chk("full", 32'(bus.full), 32'(m_full));
        chk("almost_full", 32'(bus.almost_full), 32'(ram_q.size() >= AF));
        chk("ovf", 32'(bus.ovf), 32'(m_ovf));
        chk("ram_cea", 32'(ram_cea), 32'(accept));
        chk("ram_ceb", 32'(ram_ceb), 32'(issue));
        if (accept) begin
            chk("ram_ada", 32'(ram_ada), 32'(m_wptr % DEPTH));
            chk("ram_din", 32'(ram_din), 32'(wd));
        end
        if (issue) chk("ram_adb", 32'(ram_adb), 32'(m_rptr % DEPTH));
        if (cl) begin
            model_reset();
        end else begin
            if (pop) begin
                void'(buf_q.pop_front());
                rd_count++;
            end
            if (fl_v) buf_q.push_back(fl_d);
            fl_v = issue;
            if (issue) begin
                fl_d = ram_q.pop_front();
                m_rptr++;
            end
            if (accept) begin
                ram_q.push_back(wd);
                m_wptr++;
            end
            if (we && m_full) m_ovf = 1'b1;
        end
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic step(bit we, logic [15:0] wd, bit rr, bit cl);
        drive(we, wd, rr, cl);
        finish_cycle();
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'd0);
        chk({tag, ".rd_data"},  32'(bus.rd_data),  32'd0);
        chk({tag, ".ram_cnt"},  32'(bus.ram_cnt),  32'd0);
        chk({tag, ".full"},     32'(bus.full),     32'd0);
        chk({tag, ".af"},       32'(bus.almost_full), 32'd0);
        chk({tag, ".ovf"},      32'(bus.ovf),      32'd0);
        chk({tag, ".cea"},      32'(ram_cea),      32'd0);
        chk({tag, ".ceb"},      32'(ram_ceb),      32'd0);
    endtask

    initial begin
        int n, af_cnt, w;
        bit af_seen;

        tv[0] = '{we:1'b1, wd:16'h1234, rr:1'b1, cea:1'b1, ceb:1'b0, vld:1'b0, data:16'h0,    cnt:0};
        tv[1] = '{we:1'b0, wd:16'h0,    rr:1'b1, cea:1'b0, ceb:1'b1, vld:1'b0, data:16'h0,    cnt:1};
        tv[2] = '{we:1'b0, wd:16'h0,    rr:1'b1, cea:1'b0, ceb:1'b0, vld:1'b0, data:16'h0,    cnt:0};
        tv[3] = '{we:1'b0, wd:16'h0,    rr:1'b1, cea:1'b0, ceb:1'b0, vld:1'b1, data:16'h1234, cnt:0};
        tv[4] = '{we:1'b0, wd:16'h0,    rr:1'b1, cea:1'b0, ceb:1'b0, vld:1'b0, data:16'h0,    cnt:0};

        bus.clr = 1'b0; bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // 1: single-word latency
        for (int i = 0; i < 5; i++) begin
            drive(tv[i].we, tv[i].wd, tv[i].rr, 1'b0);
            chk($sformatf("t1[%0d].cea", i), 32'(ram_cea), 32'(tv[i].cea));
            if (tv[i].cea) chk($sformatf("t1[%0d].ada", i), 32'(ram_ada), 32'd0);
            chk($sformatf("t1[%0d].ceb", i), 32'(ram_ceb), 32'(tv[i].ceb));
            chk($sformatf("t1[%0d].vld", i), 32'(bus.rd_valid), 32'(tv[i].vld));
            if (tv[i].vld) chk($sformatf("t1[%0d].data", i), 32'(bus.rd_data), 32'(tv[i].data));
            chk($sformatf("t1[%0d].cnt", i), 32'(bus.ram_cnt), 32'(tv[i].cnt));
            finish_cycle();
        end

        // 2: fill until full with no reads
        n = 0; af_seen = 1'b0; af_cnt = -1;
        for (int i = 0; i < 2100 && ram_q.size() < DEPTH; i++) begin
            step(1'b1, 16'(i), 1'b0, 1'b0);
            n++;
            if (n == 2048) chk("fill.cnt_at_2048", 32'(bus.ram_cnt), 32'd2046);
            if (!af_seen && bus.almost_full) begin
                af_seen = 1'b1;
                af_cnt  = int'(bus.ram_cnt);
            end
        end
        chk("fill.full", 32'(bus.full), 32'd1);
        chk("fill.af_level", 32'(af_cnt), 32'(AF));
        chk("fill.accepted", 32'(n), 32'd2050);
        chk("fill.ovf_before", 32'(bus.ovf), 32'd0);
        step(1'b1, 16'hDEAD, 1'b0, 1'b0);
        chk("fill.ovf_set", 32'(bus.ovf), 32'd1);
        chk("fill.cnt_hold", 32'(bus.ram_cnt), 32'd2048);

        // 5: drain to 100 resident, then clr with a read in flight
        for (int i = 0; i < 2100 && ram_q.size() > 100; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("clr.pre_cnt", 32'(bus.ram_cnt), 32'd100);
        chk("clr.pre_inflight", 32'(fl_v), 32'd1);
        step(1'b0, 16'h0, 1'b1, 1'b1);
        chk("clr.cnt", 32'(bus.ram_cnt), 32'd0);
        chk("clr.rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("clr.ovf", 32'(bus.ovf), 32'd0);
        step(1'b1, 16'hBEEF, 1'b0, 1'b0);
        w = 0;
        while (!bus.rd_valid && w < 8) begin
            step(1'b0, 16'h0, 1'b0, 1'b0);
            w++;
        end
        chk("clr.beef_valid", 32'(bus.rd_valid), 32'd1);
        chk("clr.beef_data", 32'(bus.rd_data), 32'h0000BEEF);
        chk("clr.beef_latency", 32'(w), 32'd2);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1, 1'b0);

        // 3: streaming with wrap
        rd_count = 0;
        for (int i = 0; i < 5000; i++) step(1'b1, 16'(i), 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("stream.reads", 32'(rd_count), 32'd5000);
        chk("stream.ovf", 32'(bus.ovf), 32'd0);
        chk("stream.wrapped", 32'(m_wptr >= 2 * DEPTH), 32'd1);

        // 4: continuous writes, random backpressure
        for (int i = 0; i < 3000; i++) step(1'b1, 16'($urandom), 1'($urandom % 2), 1'b0);

        // 6: asynchronous reset mid-cycle while streaming
        step(1'b1, 16'h0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 16'(i + 100), 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async");
        model_reset();
        bus.wr_en = 1'b0;
        bus.rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        step(1'b1, 16'hA5A5, 1'b0, 1'b0);
        w = 0;
        while (!bus.rd_valid && w < 8) begin
            step(1'b0, 16'h0, 1'b0, 1'b0);
            w++;
        end
        chk("async.post_valid", 32'(bus.rd_valid), 32'd1);
        chk("async.post_data", 32'(bus.rd_data), 32'h0000A5A5);
        chk("async.post_latency", 32'(w), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sdpb_fifo_ctrl
`default_nettype wire
